carry_resolve: RTL and testbench

CARRY_RESOLVE -- requirements
Module: carry_resolve

---
 rtl/carry_resolve.sv | 106 ++++++++++
 tb/tb_carry_resolve.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_resolve.sv
// carry_resolve: iterative carry resolution of a propagate/generate pair.
// Takes p = a^b and g = a&b, then folds the pending carry vector into the
// partial sum one bit position per cycle until no carry is left.
// Optional feature: define CARRY_RESOLVE_OVF_EN to add the signed-overflow
// output 'ovf'.
module carry_resolve #(
   parameter int N = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           p_in,
   input  logic [N-1:0]           g_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N-1:0]           sum_out,
   output logic                   cout,
   output logic [$clog2(N+1)-1:0] iter_cnt
`ifdef CARRY_RESOLVE_OVF_EN
   ,
   output logic                   ovf
`endif
);

   localparam int CW = $clog2(N+1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state, state_nx;
   logic [N-1:0]   s;        // partial sum
   logic [N-1:0]   c;        // carries still to be folded in
   logic [N-1:0]   t;        // carries produced by this fold
   logic           cout_r;
   logic [CW-1:0]  cnt;
   logic           accept;

   assign accept = (state == IDLE) && in_valid;
   assign t      = s & c;

   // State register; reset aborts whatever is in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: accept in IDLE, finish once no carry remains, release on out_ready.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = BUSY;
         BUSY:    if (c == '0)   state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // Datapath: load on accept, one carry fold per BUSY cycle, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         s      <= '0;
         c      <= '0;
         cout_r <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         s      <= p_in;
         c      <= {g_in[N-2:0], 1'b0};
         cout_r <= g_in[N-1];
         cnt    <= '0;
      end else if (state == BUSY && c != '0) begin
         s      <= s ^ c;
         c      <= {t[N-2:0], 1'b0};
         cout_r <= cout_r | t[N-1];
         cnt    <= cnt + CW'(1);
      end
   end

`ifdef CARRY_RESOLVE_OVF_EN
   logic p_msb, g_msb, ovf_r;

   // Overflow: operands share a sign (p msb = 0, sign = g msb) and the final
   // sum's sign differs; latched when the last fold completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_msb <= 1'b0;
         g_msb <= 1'b0;
         ovf_r <= 1'b0;
      end else if (accept) begin
         p_msb <= p_in[N-1];
         g_msb <= g_in[N-1];
         ovf_r <= 1'b0;
      end else if (state == BUSY && c == '0) begin
         ovf_r <= ~p_msb & (s[N-1] ^ g_msb);
      end
   end

   assign ovf = ovf_r;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum_out   = s;
   assign cout      = cout_r;
   assign iter_cnt  = cnt;

endmodule

// File: tb/tb_carry_resolve.sv
// Scoreboard bench for carry_resolve: the driver pushes model results at
// accept time, a monitor pops and compares on each output handshake.
module tb_carry_resolve;

   localparam int N  = 16;
   localparam int CW = $clog2(N+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  p_in = '0;
   logic [N-1:0]  g_in = '0;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  sum_out;
   logic          cout;
   logic [CW-1:0] iter_cnt;
`ifdef CARRY_RESOLVE_OVF_EN
   logic          ovf;
`endif

   logic rand_or  = 1'b0;
   logic or_force = 1'b1;
   logic rnd_or   = 1'b0;
   assign out_ready = rand_or ? rnd_or : or_force;

   carry_resolve #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .p_in(p_in), .g_in(g_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_out(sum_out), .cout(cout), .iter_cnt(iter_cnt)
`ifdef CARRY_RESOLVE_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      rnd_or = 1'($urandom_range(0, 1));
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [N-1:0] sum;
      logic         co;
      int           iters;
      logic         ov;
      int           acc;
   } exp_t;

   exp_t sb[$];

   // Reference: true addition for sum/cout/overflow; iteration count is the
   // longest carry travel distance (gen bit to receiving bit) inside the word.
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t       r;
      logic [N:0] full;
      logic [N:0] cin;
      full    = {1'b0, a} + {1'b0, b};
      r.sum   = full[N-1:0];
      r.co    = full[N];
      r.ov    = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
      cin     = full ^ {1'b0, a} ^ {1'b0, b};
      r.iters = 0;
      for (int i = 1; i < N; i++) begin
         if (cin[i]) begin
            int j;
            j = i - 1;
            while (j > 0 && !(a[j] & b[j])) j--;
            if (i - j > r.iters) r.iters = i - j;
         end
      end
      r.acc = 0;
      return r;
   endfunction

   // Called at posedge+2; waits for in_ready, presents the pair for one edge.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      int   w;
      w = 0;
      while (in_ready !== 1'b1 && w < 200) begin
         @(posedge clk); #2;
         w++;
      end
      if (in_ready !== 1'b1) begin
         chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
         return;
      end
      e     = model(a, b);
      e.acc = cyc + 1;
      sb.push_back(e);
      p_in     = a ^ b;
      g_in     = a & b;
      in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 500) begin
         @(posedge clk); #2;
         w++;
      end
      chk("drain", sb.size(), 32'd0);
   endtask

   // Monitor: latency on first out_valid, result on handshake.
   bit seen = 1'b0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
         end else begin
            if (!seen) begin
               chk("latency", cyc - sb[0].acc, sb[0].iters + 1);
               seen = 1'b1;
            end
            if (out_ready) begin
               e = sb.pop_front();
               chk("sum_out",  {16'b0, sum_out},  {16'b0, e.sum});
               chk("cout",     {31'b0, cout},     {31'b0, e.co});
               chk("iter_cnt", {27'b0, iter_cnt}, e.iters);
`ifdef CARRY_RESOLVE_OVF_EN
               chk("ovf",      {31'b0, ovf},      {31'b0, e.ov});
`endif
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [N-1:0] a, b;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_sum",       {16'b0, sum_out},   32'd0);
      chk("rst_cout",      {31'b0, cout},      32'd0);
      chk("rst_iter",      {27'b0, iter_cnt},  32'd0);
`ifdef CARRY_RESOLVE_OVF_EN
      chk("rst_ovf",       {31'b0, ovf},       32'd0);
`endif
      rst = 1'b0;
      @(posedge clk); #2;

      // Directed corner pairs (a, b)
      issue(16'h0005, 16'h0000);
      wait_drain();
      issue(16'h0003, 16'h0005);
      wait_drain();
      issue(16'hFFFF, 16'h0001);
      wait_drain();
      issue(16'h7FFF, 16'h0001);
      wait_drain();

      // Backpressure in DONE with a competing in_valid
      or_force = 1'b0;
      issue(16'h0003, 16'h0005);
      w = 0;
      while (out_valid !== 1'b1 && w < 100) begin
         @(posedge clk); #2;
         w++;
      end
      chk("bp_reach_done", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         p_in = N'($urandom);
         g_in = N'($urandom) & ~p_in;
         @(posedge clk); #2;
         chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
         chk("bp_sum",       {16'b0, sum_out},   32'h0008);
         chk("bp_cout",      {31'b0, cout},      32'd0);
         chk("bp_iter",      {27'b0, iter_cnt},  32'd3);
      end
      a = 16'h00F0;
      b = 16'h0F10;
      p_in = a ^ b;
      g_in = a & b;
      or_force = 1'b1;
      @(posedge clk); #2;
      chk("bp_idle_in_ready",  {31'b0, in_ready},  32'd1);
      chk("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
      begin
         exp_t e;
         e     = model(a, b);
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #2;
      in_valid = 1'b0;
      wait_drain();

      // Reset in the middle of a long carry chain
      issue(16'hFFFF, 16'h0001);
      repeat (4) begin
         @(posedge clk); #2;
      end
      rst = 1'b1;
      void'(sb.pop_back());
      @(posedge clk); #2;
      rst = 1'b0;
      chk("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_sum",       {16'b0, sum_out},   32'd0);
      chk("mid_rst_cout",      {31'b0, cout},      32'd0);
      chk("mid_rst_iter",      {27'b0, iter_cnt},  32'd0);
`ifdef CARRY_RESOLVE_OVF_EN
      chk("mid_rst_ovf",       {31'b0, ovf},       32'd0);
`endif
      issue(16'h1234, 16'h0FF0);
      wait_drain();

      // Randomised traffic with random consumer stalls
      rand_or = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a = N'($urandom);
         b = N'($urandom);
         if (i % 5 == 0) b = ~a + 16'd1;
         if (i % 5 == 1) a = 16'h7FFF;
         issue(a, b);
      end
      wait_drain();
      rand_or = 1'b0;

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
